keypad_entry: RTL and testbench

Scans a 4x4 active-low matrix keypad, debounces presses and assembles decimal digits into a 32-bit binary value. The live value feeds the eight-digit seven-segment display's `Number` input, so the user sees the number as it is typed. A latched value is released to the processor datapath on Enter. This is the input-side counterpart of the multiplexed display: column strobes go out, row levels come in.

---
 rtl/keypad_entry.sv | 250 +++++++++++++++++++++++++
 tb/tb_keypad_entry.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry.sv
// 4x4 active-low keypad scanner with debounce and decimal entry into a 32-bit value.
// Optional hold-to-repeat is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_entry #(
  parameter int unsigned SCAN_BITS    = 17,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [31:0] Number,
  output logic [31:0] Value,
  output logic        value_valid,
  output logic [3:0]  key_code,
  output logic        key_valid
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESS, RELEASE} state_t;

  localparam logic [3:0] DEB_LIMIT = 4'(DEBOUNCE_CNT);

  state_t                 state_q, state_d;
  logic [3:0]             row_s1_q, row_s2_q;
  logic [SCAN_BITS-1:0]   div_q;
  logic [3:0]             col_q, col_d;
  logic [1:0]             cap_row_q, cap_row_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [31:0]            number_q, number_d;
  logic [31:0]            value_q, value_d;
  logic [3:0]             digits_q, digits_d;
  logic [3:0]             key_code_q, key_code_d;
  logic                   key_valid_q, key_valid_d;
  logic                   value_valid_q, value_valid_d;
`ifdef KEYPAD_AUTOREPEAT_EN
  logic [5:0]             hold_q, hold_d;
  logic                   rep_q, rep_d;
  logic [5:0]             hold_inc;
`endif

  logic       tick;
  logic       any_low;
  logic [1:0] low_row;
  logic [1:0] col_idx;
  logic [3:0] press_code;
  logic [3:0] cnt_inc;
  logic [31:0] num_x10;

  assign tick    = &div_q;
  assign any_low = ~&row_s2_q;
  assign cnt_inc = cnt_q + 4'd1;
  assign num_x10 = {number_q[28:0], 3'b000} + {number_q[30:0], 1'b0};

  // Lowest low row wins when several rows are pressed together.
  always_comb begin
    low_row = 2'd3;
    if (!row_s2_q[0])      low_row = 2'd0;
    else if (!row_s2_q[1]) low_row = 2'd1;
    else if (!row_s2_q[2]) low_row = 2'd2;
  end

  always_comb begin
    case (col_q)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      default: col_idx = 2'd3;
    endcase
  end

  always_comb begin
    case ({cap_row_q, col_idx})
      4'b00_00: press_code = 4'h1;
      4'b00_01: press_code = 4'h2;
      4'b00_10: press_code = 4'h3;
      4'b00_11: press_code = 4'hA;
      4'b01_00: press_code = 4'h4;
      4'b01_01: press_code = 4'h5;
      4'b01_10: press_code = 4'h6;
      4'b01_11: press_code = 4'hB;
      4'b10_00: press_code = 4'h7;
      4'b10_01: press_code = 4'h8;
      4'b10_10: press_code = 4'h9;
      4'b10_11: press_code = 4'hC;
      4'b11_00: press_code = 4'hE;
      4'b11_01: press_code = 4'h0;
      4'b11_10: press_code = 4'hF;
      default:  press_code = 4'hD;
    endcase
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  assign hold_inc = hold_q + 6'd1;
`endif

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    cap_row_d     = cap_row_q;
    cnt_d         = cnt_q;
    number_d      = number_q;
    value_d       = value_q;
    digits_d      = digits_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    value_valid_d = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    hold_d        = hold_q;
    rep_d         = rep_q;
`endif
    case (state_q)
      SCAN: begin
        if (tick) begin
          if (any_low) begin
            cap_row_d = low_row;
            cnt_d     = '0;
            state_d   = DEBOUNCE;
          end else begin
            col_d = {col_q[2:0], col_q[3]};
          end
        end
      end
      DEBOUNCE: begin
        if (tick) begin
          if (any_low && (low_row == cap_row_q)) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_LIMIT) begin
              state_d = PRESS;
              cnt_d   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
              hold_d  = '0;
              rep_d   = 1'b0;
`endif
            end
          end else begin
            state_d = SCAN;
            cnt_d   = '0;
          end
        end
      end
      PRESS: begin
        key_valid_d = 1'b1;
        key_code_d  = press_code;
        state_d     = RELEASE;
        cnt_d       = '0;
        if (press_code <= 4'd9) begin
          // A leading zero on an empty entry neither changes the value nor counts as a digit.
          if ((digits_q < 4'd8) && !((press_code == 4'd0) && (number_q == '0))) begin
            number_d = num_x10 + {28'd0, press_code};
            digits_d = digits_q + 4'd1;
          end
        end else begin
          case (press_code)
            4'hA: begin
              number_d = number_q / 32'd10;
              if (digits_q != '0) digits_d = digits_q - 4'd1;
            end
            4'hC: begin
              number_d = '0;
              digits_d = '0;
            end
            4'hF: begin
              value_d       = number_q;
              value_valid_d = 1'b1;
              number_d      = '0;
              digits_d      = '0;
            end
            default: ;
          endcase
        end
      end
      RELEASE: begin
        if (tick) begin
          if (!any_low) begin
            cnt_d = cnt_inc;
`ifdef KEYPAD_AUTOREPEAT_EN
            hold_d = '0;
            rep_d  = 1'b0;
`endif
            if (cnt_inc == DEB_LIMIT) begin
              state_d = SCAN;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            // First repeat after 32 held ticks, then every 8; enter never repeats.
            if ((key_code_q != 4'hF) &&
                ((!rep_q && (hold_inc == 6'd32)) || (rep_q && (hold_inc == 6'd8)))) begin
              state_d = PRESS;
              rep_d   = 1'b1;
              hold_d  = '0;
            end else if (hold_q != 6'h3F) begin
              hold_d = hold_inc;
            end
`endif
          end
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      row_s1_q      <= '1;
      row_s2_q      <= '1;
      div_q         <= '0;
      state_q       <= SCAN;
      col_q         <= 4'b1110;
      cap_row_q     <= '0;
      cnt_q         <= '0;
      number_q      <= '0;
      value_q       <= '0;
      digits_q      <= '0;
      key_code_q    <= '0;
      key_valid_q   <= 1'b0;
      value_valid_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      hold_q        <= '0;
      rep_q         <= 1'b0;
`endif
    end else begin
      row_s1_q      <= row_in;
      row_s2_q      <= row_s1_q;
      div_q         <= div_q + SCAN_BITS'(1);
      state_q       <= state_d;
      col_q         <= col_d;
      cap_row_q     <= cap_row_d;
      cnt_q         <= cnt_d;
      number_q      <= number_d;
      value_q       <= value_d;
      digits_q      <= digits_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      value_valid_q <= value_valid_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      hold_q        <= hold_d;
      rep_q         <= rep_d;
`endif
    end
  end

  assign col_out     = col_q;
  assign Number      = number_q;
  assign Value       = value_q;
  assign value_valid = value_valid_q;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: a matrix keypad model drives rows from the column strobes,
// and expected key/value events are queued at stimulus time and popped when the DUT pulses.
module tb_keypad_entry;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [31:0] Number;
  logic [31:0] Value;
  logic        value_valid;
  logic [3:0]  key_code;
  logic        key_valid;

  logic [15:0] keys = '0;   // bit r*4+c set means key at row r, column c is held

  keypad_entry #(.SCAN_BITS(2), .DEBOUNCE_CNT(3)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .row_in(row_in), .col_out(col_out),
    .Number(Number), .Value(Value), .value_valid(value_valid),
    .key_code(key_code), .key_valid(key_valid)
  );

  always #5 Clk = ~Clk;

  always_comb begin
    row_in = '1;
    for (int r = 0; r < 4; r++)
      row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
  end

  typedef struct { logic [3:0] code; logic [31:0] num; } kexp_t;
  kexp_t       kq[$];
  logic [31:0] vq[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_num = '0;
  int          m_dig = 0;
  logic [3:0]  lut [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                            4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC,
                            4'hE, 4'h0, 4'hF, 4'hD};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_key(input logic [3:0] code);
    if (code <= 4'd9) begin
      if (m_dig < 8 && !(code == 4'd0 && m_num == 0)) begin
        m_num = m_num * 10 + 32'(code);
        m_dig++;
      end
    end else if (code == 4'hA) begin
      m_num = m_num / 10;
      if (m_dig > 0) m_dig--;
    end else if (code == 4'hC) begin
      m_num = 0;
      m_dig = 0;
    end else if (code == 4'hF) begin
      vq.push_back(m_num);
      m_num = 0;
      m_dig = 0;
    end
    kq.push_back('{code: code, num: m_num});
  endtask

  task automatic press(input logic [3:0] code);
    int idx;
    idx = 0;
    for (int i = 0; i < 16; i++) if (lut[i] == code) idx = i;
    model_key(code);
    keys[idx] = 1'b1;
    repeat (80) @(negedge Clk);
    keys = '0;
    repeat (40) @(negedge Clk);
  endtask

  // Scoreboard: every pulse must match the oldest queued expectation.
  always @(negedge Clk) begin
    if (Rst_n) begin
      check("col_one_low", 32'($countones(~col_out)), 32'd1);
      if (key_valid) begin
        check("key_expected", 32'(kq.size() != 0), 32'd1);
        if (kq.size() != 0) begin
          kexp_t e;
          e = kq.pop_front();
          check("key_code", 32'(key_code), 32'(e.code));
          check("key_number", Number, e.num);
        end
      end
      if (value_valid) begin
        check("value_expected", 32'(vq.size() != 0), 32'd1);
        if (vq.size() != 0) begin
          logic [31:0] v;
          v = vq.pop_front();
          check("value", Value, v);
          check("number_after_enter", Number, 32'd0);
        end
      end
    end
  end

  initial begin
    logic [3:0] prev;
    bit         found;

    // Reset state
    repeat (3) @(negedge Clk);
    check("rst_col", 32'(col_out), 32'b1110);
    check("rst_number", Number, 32'd0);
    check("rst_value", Value, 32'd0);
    check("rst_key_code", 32'(key_code), 32'd0);
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_value_valid", 32'(value_valid), 32'd0);
    Rst_n = 1'b1;
    repeat (100) @(negedge Clk);
    check("idle_number", Number, 32'd0);
    check("idle_value", Value, 32'd0);

    // Single long press
    press(4'h5);
    check("single_number", Number, 32'd5);
    check("single_code", 32'(key_code), 32'd5);

    // Eight digits, ninth ignored, backspace, enter
    press(4'hC);
    for (int d = 1; d <= 9; d++) press(4'(d));
    check("eight_digits", Number, 32'd12345678);
    press(4'hA);
    check("backspace", Number, 32'd1234567);
    press(4'hF);
    check("enter_value", Value, 32'd1234567);
    check("enter_number", Number, 32'd0);

    // Bounce on r0/c0: too short to debounce
    keys[0] = 1'b1; repeat (4) @(negedge Clk);
    keys[0] = 1'b0; repeat (4) @(negedge Clk);
    keys[0] = 1'b1; repeat (8) @(negedge Clk);
    keys[0] = 1'b0; repeat (40) @(negedge Clk);
    check("bounce_number", Number, 32'd0);
    press(4'h1);
    check("after_bounce_code", 32'(key_code), 32'd1);

    // r0 and r2 both low on column 2: row 0 wins
    model_key(4'h3);
    keys[0*4+2] = 1'b1;
    keys[2*4+2] = 1'b1;
    repeat (80) @(negedge Clk);
    keys = '0;
    repeat (40) @(negedge Clk);
    check("multi_code", 32'(key_code), 32'd3);
    check("multi_number", Number, 32'd13);

    // Reset while debouncing a key with 42 entered
    press(4'hC);
    press(4'h4);
    press(4'h2);
    check("pre_reset_number", Number, 32'd42);
    found = 1'b0;
    prev  = col_out;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge Clk);
      if (col_out == 4'b1101 && prev != 4'b1101) found = 1'b1;
      prev = col_out;
    end
    check("column_reached", 32'(found), 32'd1);
    keys[1*4+1] = 1'b1;
    repeat (8) @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    m_num = 0;
    m_dig = 0;
    check("async_col", 32'(col_out), 32'b1110);
    check("async_number", Number, 32'd0);
    check("async_value", Value, 32'd0);
    check("async_key_code", 32'(key_code), 32'd0);
    check("async_key_valid", 32'(key_valid), 32'd0);
    check("async_value_valid", 32'(value_valid), 32'd0);
    keys = '0;
    repeat (5) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (100) @(negedge Clk);
    check("post_reset_number", Number, 32'd0);
    check("post_reset_key_code", 32'(key_code), 32'd0);

    check("keys_outstanding", 32'(kq.size()), 32'd0);
    check("values_outstanding", 32'(vq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
